stopwatch_lap_core: RTL and testbench

Parametrised stopwatch core that counts BCD time, records lap values, and recalls them for display. It has a built-in tick divider, up/down count modes with a loadable preset, and a lap memory of configurable depth. It sits between the debounced key-control logic and the seven-segment display driver, and replaces the separate divider/counter/RAM arrangement with a single-clock block.

---
 rtl/stopwatch_pkg.sv | 8 +
 rtl/bcd_updown.sv | 24 ++
 rtl/stopwatch_lap_core.sv | 100 ++++++++++
 tb/tb_stopwatch_lap_core.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state type, BCD limit and preset sanitiser for the stopwatch core
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
   function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
      return (nibble > BCD_MAX) ? BCD_MAX : nibble;
   endfunction
endpackage

// File: rtl/bcd_updown.sv
// bcd_updown: combinational ripple BCD incrementer/decrementer across DIGITS digits
module bcd_updown import stopwatch_pkg::*; #(
   parameter int DIGITS = 6
) (
   input  logic [4*DIGITS-1:0] value,
   input  logic                dir,
   input  logic                en,
   output logic [4*DIGITS-1:0] result,
   output logic                wrap,
   output logic                zero
);
   logic [DIGITS:0] c;
   assign c[0] = en;
   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      logic [3:0] v;
      logic lim;
      assign v = value[4*d +: 4];
      assign lim = dir ? (v == 4'd0) : (v >= BCD_MAX);
      assign result[4*d +: 4] = !c[d] ? v : lim ? (dir ? BCD_MAX : 4'd0) : dir ? v - 4'd1 : v + 4'd1;
      assign c[d+1] = c[d] & lim;
   end
   assign wrap = c[DIGITS];
   assign zero = result == '0;
endmodule

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: BCD stopwatch with tick divider, up/down count, lap memory and recall
module stopwatch_lap_core import stopwatch_pkg::*; #(
   parameter  int CLK_HZ  = 50_000_000,
   parameter  int TICK_HZ = 1000,
   parameter  int DIGITS  = 6,
   parameter  int LAPS    = 8,
   localparam int W       = 4 * DIGITS,
   localparam int IW      = (LAPS > 1) ? $clog2(LAPS) : 1,
   localparam int CW      = $clog2(LAPS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_start,
   input  logic          key_pause,
   input  logic          key_lap,
   input  logic          key_recall,
   input  logic          key_clear,
   input  logic          key_load,
   input  logic          mode_down,
   input  logic [W-1:0]  preset,
   output logic [W-1:0]  disp,
   output logic          disp_src,
   output logic [IW-1:0] lap_idx,
   output logic [CW-1:0] lap_count,
   output logic          lap_full,
   output logic          running,
   output logic          expired,
   output logic          overflow
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   state_t state, state_n;
   logic [W-1:0] count, count_n, step, pre;
   logic [W-1:0] laps [LAPS];
   logic [DW-1:0] div;
   logic [IW-1:0] idx_n;
   logic idle, tick, adv, expire, wrap, zero, dir, first, src_n;
   logic pa, la, re, ld, cl;
   assign idle     = state == IDLE;
   assign running  = state == RUN;
   assign lap_full = lap_count == CW'(LAPS);
   assign tick     = running && div == DW'(DIV - 1);
   // Only applicable keys compete; start always applies
   assign pa = key_pause && !idle && !key_start;
   assign la = key_lap && !idle && !lap_full && !key_start && !key_pause;
   assign re = key_recall && idle && lap_count != '0 && !key_start;
   assign ld = key_load && idle && !key_start && !re;
   assign cl = key_clear && idle && !key_start && !re && !key_load;
   assign adv    = tick && !key_start && !key_pause;
   assign expire = adv && dir && (zero || wrap);
   bcd_updown #(.DIGITS(DIGITS)) u_step (
      .value (count),
      .dir   (dir),
      .en    (1'b1),
      .result(step),
      .wrap  (wrap),
      .zero  (zero)
   );
   always_comb begin
      pre = '0;
      for (int i = 0; i < DIGITS; i++) pre[4*i +: 4] = bcd_sat(preset[4*i +: 4]);
   end
   always_comb begin
      state_n = key_start ? (idle ? RUN : IDLE) : pa ? (running ? PAUSE : RUN) : expire ? IDLE : state;
      count_n = ld ? pre : cl ? '0 : adv ? (expire ? '0 : step) : count;
      idx_n   = cl ? '0 : !re ? lap_idx : (!first || (CW'(lap_idx) + CW'(1)) == lap_count) ? '0 : lap_idx + IW'(1);
      src_n   = re ? 1'b1 : (key_start || pa || la || ld || cl) ? 1'b0 : disp_src;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         div       <= '0;
         disp      <= '0;
         disp_src  <= 1'b0;
         lap_idx   <= '0;
         lap_count <= '0;
         expired   <= 1'b0;
         overflow  <= 1'b0;
         dir       <= 1'b0;
         first     <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         div       <= (idle || tick) ? '0 : running ? div + DW'(1) : div;
         disp      <= src_n ? laps[idx_n] : count_n;
         disp_src  <= src_n;
         lap_idx   <= idx_n;
         lap_count <= cl ? '0 : lap_count + CW'(la);
         expired   <= expire || (expired && !cl && !(key_start && idle));
         overflow  <= (adv && !dir && wrap) || (overflow && !cl);
         dir       <= idle ? mode_down : dir;
         first     <= idle && !key_start && (first || re);
      end
   end
   // Lap storage needs no reset; writes are gated by a non-IDLE state, which reset forces
   always_ff @(posedge clk) begin
      if (la) laps[IW'(lap_count)] <= count;
   end
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// tb_stopwatch_lap_core: directed test-plan scenarios plus randomized keys against a decimal-value reference model
module tb_stopwatch_lap_core;
   localparam int LAPS = 3;
   localparam int DIV  = 10;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;
   logic clk = 1'b0, rst_n = 1'b0, mode_down = 1'b0;
   logic [5:0] keys = '0;
   logic [7:0] preset = '0, disp;
   logic [1:0] lap_idx, lap_count;
   logic disp_src, lap_full, running, expired, overflow;
   int checks = 0, errors = 0;
   int m_state, m_val, m_phase, m_idx;
   bit m_dir, m_first, m_src, m_exp, m_ovf;
   int m_laps[$];
   int rexp[4] = '{1, 2, 3, 1};
   stopwatch_lap_core #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .LAPS(LAPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_start (keys[0]),
      .key_pause (keys[1]),
      .key_lap   (keys[2]),
      .key_recall(keys[3]),
      .key_load  (keys[4]),
      .key_clear (keys[5]),
      .mode_down (mode_down),
      .preset    (preset),
      .disp      (disp),
      .disp_src  (disp_src),
      .lap_idx   (lap_idx),
      .lap_count (lap_count),
      .lap_full  (lap_full),
      .running   (running),
      .expired   (expired),
      .overflow  (overflow)
   );
   always #5 clk = ~clk;
   function automatic int to_bcd(input int v);
      return (v / 10) * 16 + v % 10;
   endfunction
   function automatic int san(input logic [7:0] p);
      int hi, lo;
      hi = (p[7:4] > 9) ? 9 : int'(p[7:4]);
      lo = (p[3:0] > 9) ? 9 : int'(p[3:0]);
      return hi * 10 + lo;
   endfunction
   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_state = S_IDLE; m_val = 0; m_phase = 0; m_idx = 0;
      m_dir = 0; m_first = 0; m_src = 0; m_exp = 0; m_ovf = 0;
      m_laps.delete();
   endtask
   task automatic model_step();
      int k;
      bit idle, tick, adv;
      if (!rst_n) begin
         model_reset();
         return;
      end
      idle = m_state == S_IDLE;
      k = -1;
      if (keys[0]) k = 0;
      else if (keys[1] && !idle) k = 1;
      else if (keys[2] && !idle && m_laps.size() < LAPS) k = 2;
      else if (keys[3] && idle && m_laps.size() > 0) k = 3;
      else if (keys[4] && idle) k = 4;
      else if (keys[5] && idle) k = 5;
      tick = m_state == S_RUN && m_phase == DIV - 1;
      adv = tick && k != 0 && k != 1;
      if (m_state == S_RUN) m_phase = (m_phase + 1) % DIV;
      case (k)
         0: begin
            m_src = 0;
            if (idle) begin m_state = S_RUN; m_exp = 0; m_first = 0; m_dir = mode_down; end
            else m_state = S_IDLE;
         end
         1: begin m_src = 0; m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN; end
         2: begin m_src = 0; m_laps.push_back(m_val); end
         3: begin m_idx = m_first ? (m_idx + 1) % m_laps.size() : 0; m_first = 1; m_src = 1; end
         4: begin m_src = 0; m_val = san(preset); end
         5: begin m_src = 0; m_val = 0; m_laps.delete(); m_idx = 0; m_ovf = 0; m_exp = 0; end
         default: ;
      endcase
      if (adv) begin
         if (!m_dir) begin
            if (m_val == 99) m_ovf = 1;
            m_val = (m_val + 1) % 100;
         end else if (m_val <= 1) begin
            m_val = 0; m_exp = 1; m_state = S_IDLE;
         end else m_val = m_val - 1;
      end
      if (m_state == S_IDLE) m_phase = 0;
   endtask
   task automatic compare();
      chk("disp", int'(disp), to_bcd(m_src ? m_laps[m_idx] : m_val));
      chk("disp_src", int'(disp_src), int'(m_src));
      chk("lap_idx", int'(lap_idx), m_idx);
      chk("lap_count", int'(lap_count), m_laps.size());
      chk("lap_full", int'(lap_full), int'(m_laps.size() == LAPS));
      chk("running", int'(running), int'(m_state == S_RUN));
      chk("expired", int'(expired), int'(m_exp));
      chk("overflow", int'(overflow), int'(m_ovf));
   endtask
   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
      keys = '0;
   endtask
   task automatic wait_n(input int n);
      repeat (n) cyc();
   endtask
   task automatic hit(input int k);
      keys = 6'(1 << k);
      cyc();
   endtask
   initial begin
      model_reset();
      wait_n(2);
      rst_n = 1'b1;
      wait_n(1);
      // start, stop after 35 cycles
      hit(0); wait_n(34); hit(0);
      chk("t1_disp", int'(disp), 'h03); chk("t1_running", int'(running), 0);
      chk("t1_model", to_bcd(m_val), 'h03);
      wait_n(5);
      chk("t1_held", int'(disp), 'h03);
      // pause preserves divider phase
      hit(5); hit(0); wait_n(24); hit(1); wait_n(100);
      chk("t2_paused", int'(disp), 'h02);
      hit(1); wait_n(4);
      chk("t2_before", int'(disp), 'h02);
      wait_n(1);
      chk("t2_after", int'(disp), 'h03);
      hit(0); hit(5);
      // up-count wrap
      preset = 8'h98; hit(4); hit(0); wait_n(10);
      chk("t3_99", int'(disp), 'h99);
      wait_n(10);
      chk("t3_00", int'(disp), 'h00); chk("t3_ovf", int'(overflow), 1);
      chk("t3_model_ovf", int'(m_ovf), 1);
      wait_n(10);
      chk("t3_01", int'(disp), 'h01);
      hit(0); hit(5);
      // down-count expiry
      mode_down = 1'b1; preset = 8'h02; hit(4); hit(0); wait_n(10);
      chk("t4_01", int'(disp), 'h01);
      wait_n(10);
      chk("t4_00", int'(disp), 'h00); chk("t4_exp", int'(expired), 1); chk("t4_idle", int'(running), 0);
      wait_n(5);
      chk("t4_hold", int'(disp), 'h00);
      mode_down = 1'b0; hit(5);
      // laps and recall
      hit(0); wait_n(14); hit(2); wait_n(9); hit(2); wait_n(9); hit(2); wait_n(9); hit(2);
      chk("t5_count", int'(lap_count), 3); chk("t5_full", int'(lap_full), 1);
      hit(0);
      for (int i = 0; i < 4; i++) begin
         hit(3);
         chk("t5_recall", int'(disp), rexp[i]); chk("t5_src", int'(disp_src), 1);
      end
      // lap coincident with tick, then async reset mid-run
      hit(5); hit(0); wait_n(59); hit(2);
      chk("t6_live", int'(disp), 'h06);
      hit(0); hit(3);
      chk("t6_lap", int'(disp), 'h05);
      hit(0); wait_n(3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_disp", int'(disp), 0); chk("t6_rst_src", int'(disp_src), 0);
      chk("t6_rst_idx", int'(lap_idx), 0); chk("t6_rst_cnt", int'(lap_count), 0);
      chk("t6_rst_full", int'(lap_full), 0); chk("t6_rst_run", int'(running), 0);
      chk("t6_rst_exp", int'(expired), 0); chk("t6_rst_ovf", int'(overflow), 0);
      model_reset();
      wait_n(2);
      rst_n = 1'b1;
      // randomized key traffic
      for (int n = 0; n < 6000; n++) begin
         for (int b = 0; b < 6; b++) keys[b] = ($urandom_range((b == 5) ? 80 : 25, 0) == 0);
         mode_down = 1'($urandom);
         preset = 8'($urandom);
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
